alu_op_sequencer: RTL and testbench

Command front-end for the 64-bit ALU operation set. Accepts one operation at a time over a valid/ready handshake and evaluates the single-cycle operations itself: NOP, NOT, AND/OR/XOR/XNOR, LSL/LSR/ASR and ADD/SUB. MUL is dispatched to the external radix-4 Booth multiplier through its start/done/clear controls. Returns a registered 64-bit result with N/Z/C/V flags over a second valid/ready handshake.

---
 rtl/alu_op_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : alu_op_sequencer
//  Function : One-at-a-time command front-end for the 64-bit ALU op set;
//             evaluates single-cycle ops locally, dispatches MUL externally.
//  Revision : 1.0
// ============================================================================
module alu_op_sequencer #(
    parameter int MUL_TIMEOUT = 63
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [63:0] cmd_a,
    input  logic [63:0] cmd_b,
    input  logic [1:0]  cmd_shamt,
    output logic        mul_start,
    output logic        mul_clear,
    input  logic        mul_done,
    input  logic [63:0] mul_result,
    output logic [31:0] mul_multiplier,
    output logic [31:0] mul_multiplicand,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [63:0] res_data,
    output logic [3:0]  res_flags,
    output logic        res_err
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EXEC     = 2'd1,
        MUL_WAIT = 2'd2,
        OUT      = 2'd3
    } state_t;

    localparam logic [3:0] c_OP_NOP   = 4'd0;
    localparam logic [3:0] c_OP_NOT_A = 4'd1;
    localparam logic [3:0] c_OP_NOT_B = 4'd2;
    localparam logic [3:0] c_OP_AND   = 4'd3;
    localparam logic [3:0] c_OP_OR    = 4'd4;
    localparam logic [3:0] c_OP_XOR   = 4'd5;
    localparam logic [3:0] c_OP_XNOR  = 4'd6;
    localparam logic [3:0] c_OP_LSL   = 4'd7;
    localparam logic [3:0] c_OP_LSR   = 4'd8;
    localparam logic [3:0] c_OP_ASR   = 4'd9;
    localparam logic [3:0] c_OP_ADD   = 4'd10;
    localparam logic [3:0] c_OP_SUB   = 4'd11;
    localparam logic [3:0] c_OP_MUL   = 4'd12;

    // Last counter value before abort: MUL_TIMEOUT cycles in MUL_WAIT in total.
    localparam logic [5:0] c_TIMEOUT_LAST = 6'(MUL_TIMEOUT - 1);

    state_t      r_state;
    logic [3:0]  r_op;
    logic [63:0] r_a;
    logic [63:0] r_b;
    logic [1:0]  r_shamt;
    logic [5:0]  r_wait_cnt;
    logic        r_mul_end;
    logic        r_cmd_ready;
    logic        r_mul_start;
    logic        r_mul_clear;
    logic [31:0] r_mul_multiplier;
    logic [31:0] r_mul_multiplicand;
    logic        r_res_valid;
    logic [63:0] r_res_data;
    logic [3:0]  r_res_flags;
    logic        r_res_err;

    logic [64:0] w_sum;
    logic [63:0] w_y;
    logic        w_c;
    logic        w_v;
    logic        w_err;

    always_comb begin
        w_sum = '0;
        w_y   = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        w_err = 1'b0;
        case (r_op)
            c_OP_NOP:   ;
            c_OP_NOT_A: w_y = ~r_a;
            c_OP_NOT_B: w_y = ~r_b;
            c_OP_AND:   w_y = r_a & r_b;
            c_OP_OR:    w_y = r_a | r_b;
            c_OP_XOR:   w_y = r_a ^ r_b;
            c_OP_XNOR:  w_y = ~(r_a ^ r_b);
            c_OP_LSL:   w_y = r_a << r_shamt;
            c_OP_LSR:   w_y = r_a >> r_shamt;
            c_OP_ASR:   w_y = 64'($signed(r_a) >>> r_shamt);
            c_OP_ADD: begin
                w_sum = {1'b0, r_a} + {1'b0, r_b};
                w_y   = w_sum[63:0];
                w_c   = w_sum[64];
                w_v   = (r_a[63] == r_b[63]) && (w_y[63] != r_a[63]);
            end
            c_OP_SUB: begin
                // Carry out of a + ~b + 1 is the "no borrow" indication.
                w_sum = {1'b0, r_a} + {1'b0, ~r_b} + 65'd1;
                w_y   = w_sum[63:0];
                w_c   = w_sum[64];
                w_v   = (r_a[63] != r_b[63]) && (w_y[63] != r_a[63]);
            end
            c_OP_MUL:   ;
            default:    w_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state            <= IDLE;
            r_op               <= '0;
            r_a                <= '0;
            r_b                <= '0;
            r_shamt            <= '0;
            r_wait_cnt         <= '0;
            r_mul_end          <= 1'b0;
            r_cmd_ready        <= 1'b0;
            r_mul_start        <= 1'b0;
            r_mul_clear        <= 1'b0;
            r_mul_multiplier   <= '0;
            r_mul_multiplicand <= '0;
            r_res_valid        <= 1'b0;
            r_res_data         <= '0;
            r_res_flags        <= '0;
            r_res_err          <= 1'b0;
        end else begin
            r_mul_start <= 1'b0;
            r_mul_clear <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (cmd_valid && r_cmd_ready) begin
                        r_op               <= cmd_op;
                        r_a                <= cmd_a;
                        r_b                <= cmd_b;
                        r_shamt            <= cmd_shamt;
                        r_mul_multiplier   <= cmd_a[31:0];
                        r_mul_multiplicand <= cmd_b[31:0];
                        r_mul_start        <= (cmd_op == c_OP_MUL);
                        r_cmd_ready        <= 1'b0;
                        r_state            <= EXEC;
                    end
                end
                EXEC: begin
                    if (r_op == c_OP_MUL) begin
                        r_wait_cnt <= '0;
                        r_mul_end  <= 1'b0;
                        r_state    <= MUL_WAIT;
                    end else begin
                        r_res_data  <= w_y;
                        r_res_flags <= {w_y[63], (w_y == 64'd0), w_c, w_v};
                        r_res_err   <= w_err;
                        r_res_valid <= 1'b1;
                        r_state     <= OUT;
                    end
                end
                MUL_WAIT: begin
                    r_wait_cnt <= r_wait_cnt + 6'd1;
                    if (r_mul_end) begin
                        // Flags come from the captured value, one cycle after the capture.
                        r_res_flags <= {r_res_data[63], (r_res_data == 64'd0), 2'b00};
                        r_res_valid <= 1'b1;
                        r_state     <= OUT;
                    end else if (mul_done) begin
                        r_res_data  <= mul_result;
                        r_res_err   <= 1'b0;
                        r_mul_clear <= 1'b1;
                        r_mul_end   <= 1'b1;
                    end else if (r_wait_cnt == c_TIMEOUT_LAST) begin
                        r_res_data  <= '0;
                        r_res_err   <= 1'b1;
                        r_mul_clear <= 1'b1;
                        r_mul_end   <= 1'b1;
                    end
                end
                OUT: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cmd_ready        = r_cmd_ready;
    assign mul_start        = r_mul_start;
    assign mul_clear        = r_mul_clear | reset;
    assign mul_multiplier   = r_mul_multiplier;
    assign mul_multiplicand = r_mul_multiplicand;
    assign res_valid        = r_res_valid;
    assign res_data         = r_res_data;
    assign res_flags        = r_res_flags;
    assign res_err          = r_res_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_op_sequencer
//  Function : Directed vector table plus multi-cycle MUL/backpressure/reset
//             sequences for alu_op_sequencer, with a small multiplier model.
//  Revision : 1.0
// ============================================================================
module tb_alu_op_sequencer;

    localparam int TO = 63;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_op = '0;
    logic [63:0] cmd_a = '0;
    logic [63:0] cmd_b = '0;
    logic [1:0]  cmd_shamt = '0;
    logic        mul_start;
    logic        mul_clear;
    logic        mul_done = 1'b0;
    logic [63:0] mul_result = '0;
    logic [31:0] mul_multiplier;
    logic [31:0] mul_multiplicand;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [63:0] res_data;
    logic [3:0]  res_flags;
    logic        res_err;

    alu_op_sequencer #(.MUL_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_shamt(cmd_shamt),
        .mul_start(mul_start), .mul_clear(mul_clear), .mul_done(mul_done),
        .mul_result(mul_result), .mul_multiplier(mul_multiplier),
        .mul_multiplicand(mul_multiplicand),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_flags(res_flags), .res_err(res_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier model: done after mul_lat cycles, held until cleared.
    logic        mul_en = 1'b1;
    int          mul_lat = 34;
    int          mul_cnt = 0;
    logic        mul_busy = 1'b0;
    int          n_start = 0;
    int          n_clear = 0;
    logic [63:0] w_prod;
    assign w_prod = $signed({{32{mul_multiplier[31]}}, mul_multiplier}) *
                    $signed({{32{mul_multiplicand[31]}}, mul_multiplicand});

    always @(posedge clk) begin
        if (mul_clear) begin
            mul_done <= 1'b0;
            mul_busy <= 1'b0;
            mul_cnt  <= 0;
        end else if (mul_start) begin
            mul_busy <= 1'b1;
            mul_cnt  <= 1;
        end else if (mul_busy && !mul_done) begin
            if (mul_en && mul_cnt == mul_lat) begin
                mul_done   <= 1'b1;
                mul_result <= w_prod;
            end else begin
                mul_cnt <= mul_cnt + 1;
            end
        end
        if (mul_start) n_start <= n_start + 1;
        if (mul_clear && !reset) n_clear <= n_clear + 1;
    end

    typedef struct {
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [1:0]  sh;
        logic [63:0] y;
        logic [3:0]  fl;
        logic        err;
    } vec_t;

    vec_t vecs[18];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns in the cycle after acceptance (EXEC).
    task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [1:0] sh);
        int n = 0;
        while (!cmd_ready && n < 20) begin
            step();
            n++;
        end
        chk("cmd_ready_wait", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_shamt = sh;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic handshake(input string tag);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk({tag, "_valid_drop"}, 64'(res_valid), 64'd0);
        chk({tag, "_cmd_ready_back"}, 64'(cmd_ready), 64'd1);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        issue(v.op, v.a, v.b, v.sh);
        chk({tag, "_valid_t1"}, 64'(res_valid), 64'd0);
        step();
        chk({tag, "_valid_t2"}, 64'(res_valid), 64'd1);
        chk({tag, "_data"}, res_data, v.y);
        chk({tag, "_flags"}, 64'(res_flags), 64'(v.fl));
        chk({tag, "_err"}, 64'(res_err), 64'(v.err));
        handshake(tag);
    endtask

    task automatic wait_res(input int bound, output int d_cyc, output int c_cyc, output int v_cyc);
        d_cyc = -1;
        c_cyc = -1;
        v_cyc = -1;
        for (int i = 0; i < bound; i++) begin
            if (mul_done && d_cyc < 0) d_cyc = cyc;
            if (mul_clear && c_cyc < 0) c_cyc = cyc;
            if (res_valid) begin
                v_cyc = cyc;
                break;
            end
            step();
        end
        chk("res_valid_arrives", 64'(v_cyc >= 0), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s_cyc, d_cyc, c_cyc, v_cyc, s0, c0;
        logic [63:0] held;

        vecs[0]  = '{4'd10, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 2'd0, 64'h8000_0000_0000_0000, 4'b1001, 1'b0};
        vecs[1]  = '{4'd11, 64'd5, 64'd5, 2'd0, 64'd0, 4'b0110, 1'b0};
        vecs[2]  = '{4'd11, 64'd0, 64'd1, 2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000, 1'b0};
        vecs[3]  = '{4'd9, 64'h8000_0000_0000_0000, 64'd0, 2'd3, 64'hF000_0000_0000_0000, 4'b1000, 1'b0};
        vecs[4]  = '{4'd8, 64'h8000_0000_0000_0000, 64'd0, 2'd3, 64'h1000_0000_0000_0000, 4'b0000, 1'b0};
        vecs[5]  = '{4'd14, 64'h1234, 64'h5678, 2'd0, 64'd0, 4'b0100, 1'b1};
        vecs[6]  = '{4'd15, 64'hFFFF, 64'h1, 2'd1, 64'd0, 4'b0100, 1'b1};
        vecs[7]  = '{4'd3, 64'h00FF_00FF_00FF_00FF, 64'h0F0F_0F0F_0F0F_0F0F, 2'd0, 64'h000F_000F_000F_000F, 4'b0000, 1'b0};
        vecs[8]  = '{4'd4, 64'h00FF_00FF_00FF_00FF, 64'h0F0F_0F0F_0F0F_0F0F, 2'd0, 64'h0FFF_0FFF_0FFF_0FFF, 4'b0000, 1'b0};
        vecs[9]  = '{4'd5, 64'h00FF_00FF_00FF_00FF, 64'h0F0F_0F0F_0F0F_0F0F, 2'd0, 64'h0FF0_0FF0_0FF0_0FF0, 4'b0000, 1'b0};
        vecs[10] = '{4'd6, 64'h00FF_00FF_00FF_00FF, 64'h0F0F_0F0F_0F0F_0F0F, 2'd0, 64'hF00F_F00F_F00F_F00F, 4'b1000, 1'b0};
        vecs[11] = '{4'd1, 64'd0, 64'd7, 2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000, 1'b0};
        vecs[12] = '{4'd2, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 2'd0, 64'd0, 4'b0100, 1'b0};
        vecs[13] = '{4'd7, 64'hC000_0000_0000_0001, 64'd0, 2'd2, 64'h0000_0000_0000_0004, 4'b0000, 1'b0};
        vecs[14] = '{4'd10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 2'd0, 64'd0, 4'b0110, 1'b0};
        vecs[15] = '{4'd0, 64'd5, 64'd6, 2'd0, 64'd0, 4'b0100, 1'b0};
        vecs[16] = '{4'd11, 64'h8000_0000_0000_0000, 64'd1, 2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011, 1'b0};
        vecs[17] = '{4'd10, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'd0, 64'd0, 4'b0111, 1'b0};

        // Reset state
        repeat (3) step();
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_res_data", res_data, 64'd0);
        chk("rst_res_flags", 64'(res_flags), 64'd0);
        chk("rst_res_err", 64'(res_err), 64'd0);
        chk("rst_mul_start", 64'(mul_start), 64'd0);
        chk("rst_mul_clear", 64'(mul_clear), 64'd1);
        chk("rst_mul_ops", 64'({mul_multiplier, mul_multiplicand}), 64'd0);
        reset = 1'b0;
        step();
        chk("rel_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rel_mul_clear", 64'(mul_clear), 64'd0);

        for (int i = 0; i < 18; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // MUL with a 34-cycle multiplier
        mul_en = 1'b1;
        s0 = n_start;
        c0 = n_clear;
        issue(4'd12, 64'hDEAD_BEEF_FFFF_FFFD, 64'h1234_5678_0000_0007, 2'd0);
        s_cyc = cyc;
        chk("mul_start_exec", 64'(mul_start), 64'd1);
        chk("mul_operands", 64'({mul_multiplier, mul_multiplicand}), 64'hFFFF_FFFD_0000_0007);
        step();
        wait_res(200, d_cyc, c_cyc, v_cyc);
        chk("mul_clear_after_done", 64'(c_cyc - d_cyc), 64'd1);
        chk("mul_valid_latency", 64'(v_cyc - d_cyc), 64'd2);
        chk("mul_data", res_data, 64'hFFFF_FFFF_FFFF_FFEB);
        chk("mul_flags", 64'(res_flags), 64'b1000);
        chk("mul_err", 64'(res_err), 64'd0);
        handshake("mul");
        chk("mul_start_count", 64'(n_start - s0), 64'd1);
        chk("mul_clear_count", 64'(n_clear - c0), 64'd1);

        // MUL timeout: mul_done never rises
        mul_en = 1'b0;
        s0 = n_start;
        c0 = n_clear;
        issue(4'd12, 64'd3, 64'd4, 2'd0);
        s_cyc = cyc;
        step();
        wait_res(200, d_cyc, c_cyc, v_cyc);
        chk("to_clear_cycle", 64'(c_cyc - s_cyc), 64'(TO + 1));
        chk("to_valid_cycle", 64'(v_cyc - s_cyc), 64'(TO + 2));
        chk("to_data", res_data, 64'd0);
        chk("to_flags", 64'(res_flags), 64'b0100);
        chk("to_err", 64'(res_err), 64'd1);
        handshake("to");
        chk("to_start_count", 64'(n_start - s0), 64'd1);
        chk("to_clear_count", 64'(n_clear - c0), 64'd1);

        // Backpressure: result held for 5 cycles
        issue(vecs[0].op, vecs[0].a, vecs[0].b, vecs[0].sh);
        step();
        chk("bp_valid", 64'(res_valid), 64'd1);
        held = res_data;
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("bp%0d_valid", k), 64'(res_valid), 64'd1);
            chk($sformatf("bp%0d_data", k), res_data, 64'h8000_0000_0000_0000);
            chk($sformatf("bp%0d_flags", k), 64'(res_flags), 64'b1001);
            chk($sformatf("bp%0d_cmd_ready", k), 64'(cmd_ready), 64'd0);
        end
        chk("bp_data_stable", res_data, 64'h8000_0000_0000_0000);
        chk("bp_held_first", held, 64'h8000_0000_0000_0000);
        handshake("bp");

        // Reset during MUL_WAIT
        mul_en = 1'b0;
        issue(4'd12, 64'd9, 64'd9, 2'd0);
        repeat (5) step();
        reset = 1'b1;
        #1;
        chk("rmw_clear_in_reset", 64'(mul_clear), 64'd1);
        step();
        chk("rmw_res_valid", 64'(res_valid), 64'd0);
        chk("rmw_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rmw_clear_held", 64'(mul_clear), 64'd1);
        reset = 1'b0;
        step();
        chk("rmw_cmd_ready_rel", 64'(cmd_ready), 64'd1);
        chk("rmw_res_valid_rel", 64'(res_valid), 64'd0);
        chk("rmw_clear_rel", 64'(mul_clear), 64'd0);
        mul_en = 1'b1;
        run_vec(vecs[16], "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
